// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU register-file constants and write-enable decoder state type
package cpu_pkg;

  localparam int REG_COUNT  = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_we_decoder_if.sv
// rtl/regfile_we_decoder_if.sv - writeback/clear bus between decode stage and write-enable decoder
interface regfile_we_decoder_if
  import cpu_pkg::*;
#(
  parameter int NUM_OUT = REG_COUNT
);
  localparam int ADDR_W = $clog2(NUM_OUT);

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic               clear_req;
  logic [NUM_OUT-1:0] we_out;
  logic               zero_wr;
  logic               busy;
  logic               clear_done;
  logic               addr_err;

  modport master (
    output wr_en, wr_addr, clear_req,
    input  we_out, zero_wr, busy, clear_done, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, clear_req,
    output we_out, zero_wr, busy, clear_done, addr_err
  );

endinterface

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational address to one-hot decoder with range flag
module onehot_dec #(
  parameter int NUM_OUT = 16
) (
  input  logic                       en,
  input  logic [$clog2(NUM_OUT)-1:0] addr,
  output logic [NUM_OUT-1:0]         onehot,
  output logic                       out_of_range
);
  logic [31:0] addr_ext;

  assign addr_ext = 32'(addr);

  // Decode by comparison so addresses past NUM_OUT give all-zero, never X.
  always_comb begin
    onehot       = '0;
    out_of_range = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      onehot[i] = en && (addr_ext == 32'(i));
    end
    out_of_range = en && (addr_ext >= 32'(NUM_OUT));
  end

endmodule

// File: rtl/regfile_we_decoder.sv
// rtl/regfile_we_decoder.sv - registered register-file write-enable decoder with clear sweep
module regfile_we_decoder
  import cpu_pkg::*;
#(
  parameter int NUM_OUT        = REG_COUNT,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_we_decoder_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_OUT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_OUT - 1);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   cnt_nxt;
  logic                done_nxt;

  logic                dec_en;
  logic [ADDR_W-1:0]   dec_addr;
  logic [NUM_OUT-1:0]  dec_onehot;
  logic                dec_oor;

  logic [NUM_OUT-1:0]  we_out_q;
  logic                zero_wr_q;
  logic                clear_done_q;
  logic                addr_err_q;

  // The single decoder serves the writeback path when idle and the sweep counter when clearing.
  always_comb begin
    dec_en   = bus.wr_en;
    dec_addr = bus.wr_addr;
    if (state == CLEAR) begin
      dec_en   = 1'b1;
      dec_addr = cnt;
    end
  end

  onehot_dec #(
    .NUM_OUT (NUM_OUT)
  ) u_dec (
    .en           (dec_en),
    .addr         (dec_addr),
    .onehot       (dec_onehot),
    .out_of_range (dec_oor)
  );

  // Next state: a clear request always (re)starts the sweep and beats the final-cycle exit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (bus.clear_req) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_IDX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and sweep counter; reset optionally lands directly in the sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output registers; writes seen while clearing are dropped because the decoder is fed by cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_out_q     <= '0;
      zero_wr_q    <= 1'b0;
      clear_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      we_out_q     <= dec_onehot;
      zero_wr_q    <= (state == CLEAR);
      clear_done_q <= done_nxt;
      addr_err_q   <= (state == IDLE) && dec_oor;
    end
  end

  assign bus.we_out     = we_out_q;
  assign bus.zero_wr    = zero_wr_q;
  assign bus.clear_done = clear_done_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.busy       = (state == CLEAR);

endmodule

// File: tb/tb_regfile_we_decoder.sv
// tb/tb_regfile_we_decoder.sv - directed self-checking bench for regfile_we_decoder
module tb_regfile_we_decoder;

  logic clk;
  logic reset_n;

  int n_checks;
  int n_fail;

  regfile_we_decoder_if #(.NUM_OUT(16)) bus_a ();
  regfile_we_decoder_if #(.NUM_OUT(12)) bus_b ();

  regfile_we_decoder #(
    .NUM_OUT        (16),
    .CLEAR_ON_RESET (1'b1)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  regfile_we_decoder #(
    .NUM_OUT        (12),
    .CLEAR_ON_RESET (1'b0)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic [31:0] exp_we;

    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.clear_req = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.clear_req = 1'b0;

    // reset state
    repeat (2) tick();
    check("rst_busy_a",   32'(bus_a.busy),       32'h1);
    check("rst_we_a",     32'(bus_a.we_out),     32'h0);
    check("rst_zero_a",   32'(bus_a.zero_wr),    32'h0);
    check("rst_done_a",   32'(bus_a.clear_done), 32'h0);
    check("rst_err_a",    32'(bus_a.addr_err),   32'h0);
    check("rst_busy_b",   32'(bus_b.busy),       32'h0);

    // sweep on reset release
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rel_busy[%0d]", i), 32'(bus_a.busy), 32'h1);
      tick();
      check($sformatf("rel_we[%0d]", i),   32'(bus_a.we_out),     32'h1 << i);
      check($sformatf("rel_zero[%0d]", i), 32'(bus_a.zero_wr),    32'h1);
      check($sformatf("rel_done[%0d]", i), 32'(bus_a.clear_done), (i == 15) ? 32'h1 : 32'h0);
    end
    check("rel_busy_end", 32'(bus_a.busy), 32'h0);
    check("b_idle_busy",  32'(bus_b.busy), 32'h0);
    tick();
    check("rel_we_after", 32'(bus_a.we_out),  32'h0);
    check("rel_zero_aft", 32'(bus_a.zero_wr), 32'h0);

    // back-to-back writes
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd5;
    tick();
    check("wr5_we",   32'(bus_a.we_out),  32'h0020);
    check("wr5_zero", 32'(bus_a.zero_wr), 32'h0);
    bus_a.wr_addr = 4'hF;
    tick();
    check("wr15_we",  32'(bus_a.we_out),  32'h8000);
    bus_a.wr_en = 1'b0;
    tick();
    check("wr_off_we", 32'(bus_a.we_out), 32'h0);

    // range check on the 12-register instance
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd13;
    tick();
    check("b13_we",  32'(bus_b.we_out),   32'h000);
    check("b13_err", 32'(bus_b.addr_err), 32'h1);
    bus_b.wr_addr = 4'd11;
    tick();
    check("b11_we",  32'(bus_b.we_out),   32'h800);
    check("b11_err", 32'(bus_b.addr_err), 32'h0);
    bus_b.wr_addr = 4'd12;
    tick();
    check("b12_we",  32'(bus_b.we_out),   32'h000);
    check("b12_err", 32'(bus_b.addr_err), 32'h1);
    bus_b.wr_en = 1'b0;
    tick();
    check("b_off_err", 32'(bus_b.addr_err), 32'h0);

    // 12-entry sweep with out-of-range writes held during it
    bus_b.clear_req = 1'b1;
    tick();
    bus_b.clear_req = 1'b0;
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd13;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("bsw_we[%0d]", i),   32'(bus_b.we_out),     32'h1 << i);
      check($sformatf("bsw_err[%0d]", i),  32'(bus_b.addr_err),   32'h0);
      check($sformatf("bsw_done[%0d]", i), 32'(bus_b.clear_done), (i == 11) ? 32'h1 : 32'h0);
    end
    check("bsw_busy_end", 32'(bus_b.busy), 32'h0);
    tick();
    check("bsw_post_err", 32'(bus_b.addr_err), 32'h1);
    check("bsw_post_we",  32'(bus_b.we_out),   32'h0);
    bus_b.wr_en = 1'b0;

    // restart at sweep index 7
    bus_a.clear_req = 1'b1;
    tick();
    check("rs_idle_we", 32'(bus_a.we_out), 32'h0);
    bus_a.clear_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus_a.busy) busy_cnt++;
      bus_a.clear_req = (i == 7);
      tick();
      if (i <= 7)       exp_we = 32'h1 << i;
      else if (i <= 23) exp_we = 32'h1 << (i - 8);
      else              exp_we = 32'h0;
      check($sformatf("rs_we[%0d]", i),   32'(bus_a.we_out),     exp_we);
      check($sformatf("rs_zero[%0d]", i), 32'(bus_a.zero_wr),    (i <= 23) ? 32'h1 : 32'h0);
      check($sformatf("rs_done[%0d]", i), 32'(bus_a.clear_done), (i == 23) ? 32'h1 : 32'h0);
      if (bus_a.clear_done) done_cnt++;
    end
    bus_a.clear_req = 1'b0;
    check("rs_busy_total", 32'(busy_cnt), 32'd24);
    check("rs_done_total", 32'(done_cnt), 32'd1);

    // write and clear request together, then writes ignored during the sweep
    bus_a.clear_req = 1'b1; bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd3;
    tick();
    check("cw_we",   32'(bus_a.we_out),  32'h0008);
    check("cw_zero", 32'(bus_a.zero_wr), 32'h0);
    check("cw_busy", 32'(bus_a.busy),    32'h1);
    bus_a.clear_req = 1'b0; bus_a.wr_addr = 4'd2;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("cw_sw[%0d]", i),  32'(bus_a.we_out),   32'h1 << i);
      check($sformatf("cw_err[%0d]", i), 32'(bus_a.addr_err), 32'h0);
    end
    check("cw_busy_end", 32'(bus_a.busy), 32'h0);
    tick();
    check("cw_first_wr",   32'(bus_a.we_out),  32'h0004);
    check("cw_first_zero", 32'(bus_a.zero_wr), 32'h0);
    bus_a.wr_en = 1'b0;
    tick();

    // reset at sweep index 9
    bus_a.clear_req = 1'b1;
    tick();
    bus_a.clear_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mr_pre_we", 32'(bus_a.we_out), 32'h0100);
    #1;
    reset_n = 1'b0;
    #1;
    check("mr_we",   32'(bus_a.we_out),  32'h0);
    check("mr_busy", 32'(bus_a.busy),    32'h1);
    check("mr_zero", 32'(bus_a.zero_wr), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("mr_sw[%0d]", i), 32'(bus_a.we_out), 32'h1 << i);
    end
    check("mr_busy_end", 32'(bus_a.busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
